// File: rtl/proc_pkg.sv
// Shared definitions for the processor slice: fetch FSM states and address constants.
package proc_pkg;

  localparam int D  = 12;
  localparam int TW = 4;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [D-1:0] START_ADDR = {D{1'b0}};

endpackage

// File: rtl/fetch_unit_target_lut.sv
// Branch-target table: maps an instruction's target index to an absolute ROM address.
module fetch_target_lut #(
  parameter int D  = 12,
  parameter int TW = 4
) (
  input  logic [TW-1:0] target_idx,
  output logic [D-1:0]  target
);

  // Program-specific targets; any index not listed resolves to address 0.
  always_comb begin
    target = {D{1'b0}};
    case (target_idx)
      TW'(2):  target = D'(12'h014);
      TW'(3):  target = D'(12'h040);
      TW'(5):  target = D'(12'h009);
      TW'(7):  target = D'(12'h123);
      TW'(15): target = D'(12'hFFF);
      default: target = {D{1'b0}};
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: start/done handshake FSM, program counter and
// saturating run-cycle counter.
module fetch_unit #(
  parameter int D  = proc_pkg::D,
  parameter int TW = proc_pkg::TW,
  parameter int CW = proc_pkg::CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          zero,
  input  logic [TW-1:0] target_idx,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_count
);
  import proc_pkg::*;

  fetch_state_t  state_q, state_d;
  logic [D-1:0]  prog_ctr_q, prog_ctr_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [D-1:0]  lut_target_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  fetch_target_lut #(.D(D), .TW(TW)) u_target_lut (
    .target_idx (target_idx),
    .target     (lut_target_s)
  );

  // Next-state, next-PC and counter selection; halt outranks a taken branch.
  always_comb begin
    state_d       = state_q;
    prog_ctr_d    = prog_ctr_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d       = RUN;
          prog_ctr_d    = START_ADDR;
          cycle_count_d = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        if (halt) begin
          state_d = DONE;
        end else if (branch_en && zero) begin
          prog_ctr_d = lut_target_s;
        end else begin
          prog_ctr_d = prog_ctr_q + D'(1);
        end
      end
      DONE: begin
        // A new start needs req to drop first, so a held req cannot re-launch.
        if (!req) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, PC, counter and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prog_ctr_q    <= START_ADDR;
      cycle_count_q <= {CW{1'b0}};
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_ctr_q    <= prog_ctr_d;
      cycle_count_q <= cycle_count_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign prog_ctr    = prog_ctr_q;
  assign running     = running_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// against a behavioural model; a CW=4 instance shares the stimulus for saturation.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, halt, branch_en, zero;
  logic [3:0]  target_idx;
  logic [11:0] prog_ctr, prog_ctr4;
  logic        running, done, running4, done4;
  logic [15:0] cycle_count;
  logic [3:0]  cycle_count4;

  int nvec = 0;
  int nerr = 0;

  // reference model: 0 idle, 1 run, 2 done; count kept unsaturated
  int m_state, m_pc, m_cnt;
  int lut_tb [16];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .branch_en(branch_en),
    .zero(zero), .target_idx(target_idx), .prog_ctr(prog_ctr),
    .running(running), .done(done), .cycle_count(cycle_count)
  );

  fetch_unit #(.CW(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .branch_en(branch_en),
    .zero(zero), .target_idx(target_idx), .prog_ctr(prog_ctr4),
    .running(running4), .done(done4), .cycle_count(cycle_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int sat16, sat4;
    sat16 = (m_cnt > 65535) ? 65535 : m_cnt;
    sat4  = (m_cnt > 15) ? 15 : m_cnt;
    check({tag, "_pc"},      {20'd0, prog_ctr},       m_pc);
    check({tag, "_running"}, {31'd0, running},        (m_state == 1) ? 1 : 0);
    check({tag, "_done"},    {31'd0, done},           (m_state == 2) ? 1 : 0);
    check({tag, "_count"},   {16'd0, cycle_count},    sat16);
    check({tag, "_count4"},  {28'd0, cycle_count4},   sat4);
    check({tag, "_pc4"},     {20'd0, prog_ctr4},      m_pc);
  endtask

  // Apply one cycle of inputs, advance the model by the spec rules, then compare.
  task automatic step(input logic r, input logic h, input logic b, input logic z,
                      input logic [3:0] idx, input string tag);
    req = r; halt = h; branch_en = b; zero = z; target_idx = idx;
    @(posedge clk);
    if (m_state == 0) begin
      if (r) begin m_state = 1; m_pc = 0; m_cnt = 0; end
    end else if (m_state == 1) begin
      m_cnt = m_cnt + 1;
      if (h) m_state = 2;
      else if (b && z) m_pc = lut_tb[idx];
      else m_pc = (m_pc + 1) % 4096;
    end else begin
      if (!r) m_state = 0;
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_tb[i] = 0;
    lut_tb[2] = 'h014; lut_tb[3] = 'h040; lut_tb[5] = 'h009;
    lut_tb[7] = 'h123; lut_tb[15] = 'hFFF;

    req = 1'b0; halt = 1'b0; branch_en = 1'b0; zero = 1'b0; target_idx = 4'd0;
    reset = 1'b1;
    m_state = 0; m_pc = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    // straight-line fetch from IDLE
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "start");
    check("start_pc0", {20'd0, prog_ctr}, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "seq");
    check("seq_pc5", {20'd0, prog_ctr}, 32'd5);
    check("seq_cnt5", {16'd0, cycle_count}, 32'd5);

    // async reset mid-program at pc 7
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "seq");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "seq");
    check("pre_reset_pc7", {20'd0, prog_ctr}, 32'd7);
    #2 reset = 1'b1;
    #1;
    m_state = 0; m_pc = 0; m_cnt = 0;
    check_model("async_reset");
    check("async_reset_running", {31'd0, running}, 32'd0);
    #2 reset = 1'b0;

    // taken and untaken branch at pc 9
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "start2");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "run9");
    check("pc9", {20'd0, prog_ctr}, 32'd9);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, "br_taken");
    check("br_taken_pc", {20'd0, prog_ctr}, 32'h040);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, "br_back");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, "br_untaken");
    check("br_untaken_pc", {20'd0, prog_ctr}, 32'd10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, "br_unlisted");
    check("br_unlisted_pc", {20'd0, prog_ctr}, 32'd0);

    // halt beats branch at pc 20, then the DONE handshake
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, "br20");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, "halt");
    check("halt_pc20", {20'd0, prog_ctr}, 32'd20);
    check("halt_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "done_hold");
    check("done_held", {31'd0, done}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "to_idle");
    check("idle_done", {31'd0, done}, 32'd0);

    // PC wrap at all-ones and counter saturation on the CW=4 instance
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "start3");
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd15, "br_fff");
    check("pc_fff", {20'd0, prog_ctr}, 32'hFFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "wrap");
    check("pc_wrap", {20'd0, prog_ctr}, 32'd0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "sat");
    check("sat_cnt4", {28'd0, cycle_count4}, 32'd15);
    check("sat_cnt16", {16'd0, cycle_count}, 32'd20);

    // dropping req mid-run does not abort
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "halt2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "idle2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "start4");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "req_low");
    check("req_low_running", {31'd0, running}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "halt3");
    check("halt3_cnt", {16'd0, cycle_count}, 32'd5);
    check("halt3_pc", {20'd0, prog_ctr}, 32'd4);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
